// File: rtl/shift_seq_if.sv
// Handshake and shifter-port bundle for shift_seq: command in, result out,
// plus the loop through the external 4-bit combinational barrel shifter.
interface shift_seq_if #(
    parameter int AMT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_data;
    logic             cmd_dir;
    logic [AMT_W-1:0] cmd_amt;

    logic [3:0]       sh_in;
    logic [1:0]       sh_shift;
    logic             sh_dir;
    logic [3:0]       sh_out;

    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_data;

    // master: the sequencer; slave: producer, consumer and shifter around it
    modport master (
        input  cmd_valid, cmd_data, cmd_dir, cmd_amt, sh_out, res_ready,
        output cmd_ready, sh_in, sh_shift, sh_dir, res_valid, res_data
    );
    modport slave (
        output cmd_valid, cmd_data, cmd_dir, cmd_amt, sh_out, res_ready,
        input  cmd_ready, sh_in, sh_shift, sh_dir, res_valid, res_data
    );
endinterface

// File: rtl/shift_seq.sv
// Multi-pass shift sequencer: splits a shift of up to 2^AMT_W-1 positions into
// passes of at most 3 through an external shifter. Option: BSEQ_EARLY_EXIT_EN.
module shift_seq #(
    parameter int AMT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    shift_seq_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       data_reg,  data_next;
    logic [AMT_W-1:0] rem_reg,   rem_next;
    logic             dir_reg,   dir_next;
    logic [1:0]       pass_amt;

    // Per-pass amount is capped at what remains, so rem_reg cannot underflow.
    assign pass_amt = (rem_reg > AMT_W'(3)) ? 2'd3 : rem_reg[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= 4'd0;
            rem_reg   <= '0;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            rem_reg   <= rem_next;
            dir_reg   <= dir_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        rem_next   = rem_reg;
        dir_next   = dir_reg;
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    data_next  = bus.cmd_data;
                    rem_next   = bus.cmd_amt;
                    dir_next   = bus.cmd_dir;
                    state_next = RUN;
`ifdef BSEQ_EARLY_EXIT_EN
                    // Any shift of 4 or more clears a 4-bit word; skip the passes.
                    if (bus.cmd_amt >= AMT_W'(4)) begin
                        data_next  = 4'd0;
                        state_next = DONE;
                    end
`endif
                end
            end
            RUN: begin
                data_next = bus.sh_out;
                rem_next  = rem_reg - AMT_W'(pass_amt);
                if (rem_reg <= AMT_W'(3)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_reg == IDLE) && !rst;
    assign bus.sh_in     = data_reg;
    assign bus.sh_dir    = dir_reg;
    assign bus.sh_shift  = (state_reg == RUN) ? pass_amt : 2'd0;
    assign bus.res_valid = (state_reg == DONE);
    assign bus.res_data  = (state_reg == DONE) ? data_reg : 4'd0;
endmodule
